systolic_operand_skewer: RTL and testbench

- Upstream feeder for the 8x8 output-stationary systolic array.
- Accepts one K-slice per handshake: column k of A (8 lanes) and row k of B (8 lanes).
- Emits diagonally skewed streams onto the array's A0..A7 and B0..B7 edge inputs. Lane i is delayed i cycles, so a(i,k) and b(k,j) meet at PE(i,j) on the same cycle.
- After K slices, flushes zeros until the last operand has reached PE(7,7), then pulses done so the controller can start readout.

---
 rtl/systolic_operand_skewer_pkg.sv | 27 ++
 rtl/skew_delay_line.sv | 30 +++
 rtl/systolic_operand_skewer.sv | 126 ++++++++++++
 tb/tb_systolic_operand_skewer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_operand_skewer_pkg.sv
// Shared constants and state encoding for the systolic operand skewer.
// Lane slices are N-bit fields packed little-endian into M*N-bit buses.
package systolic_operand_skewer_pkg;

  localparam int N_DEF  = 32;
  localparam int M_DEF  = 8;
  localparam int KW_DEF = 8;

  // Skew of M-1 plus M-1 hops across the array plus one accumulate cycle.
  function automatic int flush_len(input int m);
    return 2 * m - 1;
  endfunction

  localparam int FLUSH_LEN = flush_len(M_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    STREAM = 2'b01,
    FLUSH  = 2'b10,
    DONE   = 2'b11
  } state_t;

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register for one skewed lane; shifts every cycle with no stall.
// Output lags input by DEPTH edges; clr zeroes every stage.
module skew_delay_line #(
  parameter int N     = 32,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int s = 0; s < DEPTH; s++) begin
        r_stage[s] <= '0;
      end
    end else begin
      r_stage[0] <= d;
      for (int s = 1; s < DEPTH; s++) begin
        r_stage[s] <= r_stage[s-1];
      end
    end
  end

  assign q = r_stage[DEPTH-1];

endmodule

// File: rtl/systolic_operand_skewer.sv
// Feeds an MxM output-stationary array: lane i of A and B is delayed i+1 edges so operands meet diagonally.
// Accepts one K-slice per in_valid/in_ready cycle in STREAM, then flushes zeros and pulses done.
module systolic_operand_skewer
  import systolic_operand_skewer_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int M  = M_DEF,
  parameter int KW = KW_DEF
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           start,
  input  logic [KW-1:0]  k_len,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M*N-1:0] a_in,
  input  logic [M*N-1:0] b_in,
  output logic [M*N-1:0] a_out,
  output logic [M*N-1:0] b_out,
  output logic           busy,
  output logic           done
);

  localparam int FLUSH_CYC = flush_len(M);
  localparam int FCW       = $clog2(FLUSH_CYC);
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_CYC - 1);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [KW-1:0]  r_k_len;
  logic [KW-1:0]  r_slice_cnt;
  logic [KW-1:0]  w_slice_inc;
  logic [FCW-1:0] r_flush_cnt;
  logic           w_fire;
  logic [M*N-1:0] w_a_feed;
  logic [M*N-1:0] w_b_feed;

  assign w_fire      = in_valid && (r_state == STREAM);
  assign w_slice_inc = r_slice_cnt + KW'(1);

  // Bubbles and non-STREAM cycles push zero slices so every lane keeps shifting coherently.
  assign w_a_feed = w_fire ? a_in : '0;
  assign w_b_feed = w_fire ? b_in : '0;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (k_len == '0) ? FLUSH : STREAM;
        end
      end
      STREAM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_fire && (w_slice_inc == r_k_len)) begin
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        busy = 1'b1;
        if (r_flush_cnt == FLUSH_LAST) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_k_len     <= '0;
      r_slice_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_k_len     <= k_len;
            r_slice_cnt <= '0;
          end
        end
        STREAM: begin
          if (w_fire) begin
            r_slice_cnt <= w_slice_inc;
          end
        end
        FLUSH: begin
          r_flush_cnt <= (r_flush_cnt == FLUSH_LAST) ? '0 : r_flush_cnt + FCW'(1);
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < M; g++) begin : g_lane
    skew_delay_line #(.N(N), .DEPTH(g + 1)) u_a_line (
      .clk (clk),
      .clr (clr),
      .d   (w_a_feed[lane_lo(g, N) +: N]),
      .q   (a_out[lane_lo(g, N) +: N])
    );
    skew_delay_line #(.N(N), .DEPTH(g + 1)) u_b_line (
      .clk (clk),
      .clr (clr),
      .d   (w_b_feed[lane_lo(g, N) +: N]),
      .q   (b_out[lane_lo(g, N) +: N])
    );
  end

endmodule

// File: tb/tb_systolic_operand_skewer.sv
// Randomized bench: timestamped reference history predicts every output each cycle,
// and a software MxM array driven by the DUT outputs must reproduce C = A*B.
module tb_systolic_operand_skewer;

  localparam int N  = 32;
  localparam int M  = 8;
  localparam int KW = 8;
  localparam int FL = 2 * M - 1;
  localparam int HD = 4096;

  logic           clk = 1'b0;
  logic           clr, start, in_valid;
  logic [KW-1:0]  k_len;
  logic [M*N-1:0] a_in, b_in;
  logic           in_ready, busy, done;
  logic [M*N-1:0] a_out, b_out;

  always #5 clk = ~clk;

  systolic_operand_skewer #(.N(N), .M(M), .KW(KW)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .k_len    (k_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_in     (a_in),
    .b_in     (b_in),
    .a_out    (a_out),
    .b_out    (b_out),
    .busy     (busy),
    .done     (done)
  );

  int errors = 0;
  int checks = 0;

  // Reference: frame phase plus a history of the slice captured at every edge.
  int m_e = 0, m_last_clr = 0, m_phase = 0, m_k = 0, m_acc = 0, m_fend = 0;
  bit m_valid = 1'b0;
  logic [M*N-1:0] h_a [HD];
  logic [M*N-1:0] h_b [HD];
  logic [M*N-1:0] rec_a [HD];
  logic [M*N-1:0] rec_b [HD];
  int smp = 0;
  logic [M*N-1:0] sl_a [16];
  logic [M*N-1:0] sl_b [16];

  task automatic chk(input string name, input logic [M*N-1:0] act, input logic [M*N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic longint lane(input logic [M*N-1:0] v, input int i);
    return longint'(v[i*N +: N]);
  endfunction

  task automatic model_step();
    m_e++;
    h_a[m_e] = '0;
    h_b[m_e] = '0;
    if (clr) begin
      m_phase = 0; m_acc = 0; m_last_clr = m_e; m_valid = 1'b1;
    end else begin
      case (m_phase)
        0: if (start) begin
             m_k = int'(k_len); m_acc = 0;
             if (m_k == 0) begin m_phase = 2; m_fend = m_e + FL; end
             else m_phase = 1;
           end
        1: if (in_valid) begin
             h_a[m_e] = a_in; h_b[m_e] = b_in; m_acc++;
             if (m_acc == m_k) begin m_phase = 2; m_fend = m_e + FL; end
           end
        2: if (m_e == m_fend) m_phase = 3;
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic compare_outputs();
    logic [M*N-1:0] ea, eb;
    ea = '0; eb = '0;
    for (int i = 0; i < M; i++) begin
      if (m_e - i > m_last_clr) begin
        ea[i*N +: N] = h_a[m_e - i][i*N +: N];
        eb[i*N +: N] = h_b[m_e - i][i*N +: N];
      end
    end
    chk("a_out", a_out, ea);
    chk("b_out", b_out, eb);
    chk("in_ready", {255'b0, in_ready}, {255'b0, m_phase == 1});
    chk("busy", {255'b0, busy}, {255'b0, (m_phase == 1) || (m_phase == 2)});
    chk("done", {255'b0, done}, {255'b0, m_phase == 3});
  endtask

  // One clock: check at the falling edge, advance the reference at the rising edge, drive 2 units later.
  task automatic tick();
    @(negedge clk);
    if (m_valid) compare_outputs();
    rec_a[smp] = a_out;
    rec_b[smp] = b_out;
    smp++;
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic fill_rand(input int k);
    for (int kk = 0; kk < k; kk++) begin
      for (int i = 0; i < M; i++) begin
        sl_a[kk][i*N +: N] = N'($urandom_range(0, 255));
        sl_b[kk][i*N +: N] = N'($urandom_range(0, 255));
      end
    end
  endtask

  task automatic check_product(input int klen, input int s0, input int s1);
    longint ec, gc;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < M; j++) begin
        ec = 0; gc = 0;
        for (int kk = 0; kk < klen; kk++) ec += lane(sl_a[kk], i) * lane(sl_b[kk], j);
        for (int s = s0; s < s1; s++) begin
          if (s - j >= s0 && s - i >= s0) gc += lane(rec_a[s - j], i) * lane(rec_b[s - i], j);
        end
        chk($sformatf("C[%0d][%0d]", i, j), (M*N)'(gc), (M*N)'(ec));
      end
    end
  endtask

  task automatic run_frame(input int klen, input int bub_after, input int bub_len, input bit rnd_valid,
                           input int start_pulse_cyc, input int exp_done, input int exp_rdy,
                           output int s0, output int hs_smp);
    int idx, bub, cyc, rdy, done_cyc;
    bit v, hs, got_done;
    s0 = smp; hs_smp = -1;
    start = 1'b1; k_len = KW'(klen);
    tick();
    start = 1'b0; k_len = KW'($urandom);
    idx = 0; bub = bub_len; cyc = 0; rdy = 0; done_cyc = -1; got_done = 1'b0;
    while (!got_done && cyc < 400) begin
      start = (cyc == start_pulse_cyc);
      v = 1'b0;
      if (idx < klen) begin
        if (rnd_valid) v = ($urandom_range(0, 2) != 0);
        else if (idx == bub_after && bub > 0) begin
          if (in_ready) bub--;
        end else v = 1'b1;
      end
      in_valid = v;
      a_in = v ? sl_a[idx] : {M{$urandom}};
      b_in = v ? sl_b[idx] : {M{$urandom}};
      if (in_ready) rdy++;
      hs = v && in_ready;
      if (hs && hs_smp < 0) hs_smp = smp;
      if (done) begin got_done = 1'b1; done_cyc = cyc; end
      tick();
      if (hs) idx++;
      cyc++;
    end
    in_valid = 1'b0; start = 1'b0;
    chk("done_seen", {255'b0, got_done}, {255'b0, 1'b1});
    chk("slices_taken", (M*N)'(idx), (M*N)'(klen));
    if (exp_done >= 0) chk("done_cycle", (M*N)'(done_cyc), (M*N)'(exp_done));
    if (exp_rdy >= 0) chk("ready_cycles", (M*N)'(rdy), (M*N)'(exp_rdy));
    check_product(klen, s0, smp);
  endtask

  initial begin
    int s0, hs, nz;
    clr = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; a_in = '0; b_in = '0;
    repeat (3) tick();
    clr = 1'b0;
    chk("rst_a_out", a_out, '0);
    chk("rst_busy", {255'b0, busy}, '0);
    chk("rst_in_ready", {255'b0, in_ready}, '0);

    // Skew timing: single slice, lane i carries i+1 on A and i+11 on B.
    for (int i = 0; i < M; i++) begin
      sl_a[0][i*N +: N] = N'(i + 1);
      sl_b[0][i*N +: N] = N'(i + 11);
    end
    run_frame(1, -1, 0, 1'b0, -1, 16, 1, s0, hs);
    for (int i = 0; i < M; i++) begin
      chk($sformatf("skew_a%0d", i), (M*N)'(lane(rec_a[hs + 1 + i], i)), (M*N)'(i + 1));
      chk($sformatf("skew_b%0d", i), (M*N)'(lane(rec_b[hs + 1 + i], i)), (M*N)'(i + 11));
      nz = 0;
      for (int s = s0; s < smp; s++) if (lane(rec_a[s], i) != 0 || lane(rec_b[s], i) != 0) nz++;
      chk($sformatf("skew_once%0d", i), (M*N)'(nz), (M*N)'(1));
    end

    // Identity x random, back-to-back.
    fill_rand(8);
    for (int kk = 0; kk < 8; kk++)
      for (int i = 0; i < M; i++) sl_a[kk][i*N +: N] = N'(i == kk);
    run_frame(8, -1, 0, 1'b0, -1, 23, 8, s0, hs);

    // Random x random, with a stray start during FLUSH.
    fill_rand(8);
    run_frame(8, -1, 0, 1'b0, 12, 23, 8, s0, hs);
    repeat (3) tick();
    chk("no_second_frame", {255'b0, busy}, '0);

    // Two bubbles between slices 2 and 3.
    fill_rand(4);
    run_frame(4, 2, 2, 1'b0, -1, 21, 6, s0, hs);

    // Zero-length frame.
    run_frame(0, -1, 0, 1'b0, -1, 15, 0, s0, hs);
    tick();

    // clr mid-STREAM, then a fresh frame.
    fill_rand(8);
    start = 1'b1; k_len = 8'd8;
    tick();
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; a_in = sl_a[c]; b_in = sl_b[c];
      tick();
    end
    clr = 1'b1;
    repeat (3) tick();
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_a_out", a_out, '0);
    chk("clr_b_out", b_out, '0);
    chk("clr_busy", {255'b0, busy}, '0);
    chk("clr_in_ready", {255'b0, in_ready}, '0);
    chk("clr_done", {255'b0, done}, '0);
    fill_rand(5);
    run_frame(5, -1, 0, 1'b0, -1, 20, 5, s0, hs);

    // Random frames with random valid gaps.
    for (int f = 0; f < 4; f++) begin
      int k;
      k = $urandom_range(1, 12);
      fill_rand(k);
      run_frame(k, -1, 0, 1'b1, -1, -1, -1, s0, hs);
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
